// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: SPI-slave command decoder for the analog front-end.
// Oversamples the host SPI pins in the clk_12mhz domain, decodes 2-byte
// (command, data) frames, drives selector/device-select/relay lines and
// streams a {count_p,count_m} snapshot on spi_miso for the read command.
// Optional feature macro: SPI_CTRL_WDOG_EN (stalled-frame watchdog).
module spi_cmd_ctrl #(
  parameter int CNT_W     = 24,
  parameter int SEL_W     = 4,
  parameter int RLY_PULSE = 12000
`ifdef SPI_CTRL_WDOG_EN
  , parameter int WDOG_CYC = 120000
`endif
) (
  input  logic             clk_12mhz,
  input  logic             rst,
  input  logic             spi_clk,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  output logic             spi_miso,
  input  logic [CNT_W-1:0] count_p,
  input  logic [CNT_W-1:0] count_m,
  output logic [SEL_W-1:0] input_sel,
  output logic [SEL_W-1:0] mu_sel,
  output logic [SEL_W-1:0] avk_sel,
  output logic [SEL_W-1:0] fil1_sel,
  output logic [SEL_W-1:0] fil2_sel,
  output logic             comp1_cs,
  output logic             comp2_cs,
  output logic             relay_cs,
  output logic             relay_reset,
  output logic             frame_err
);
  localparam int RD_W  = 2 * CNT_W;
  localparam int CW    = $clog2(RD_W + 1);
  localparam int RLY_W = $clog2(RLY_PULSE + 1);
`ifdef SPI_CTRL_WDOG_EN
  localparam int WD_W  = $clog2(WDOG_CYC + 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_DATA, S_EXEC, S_READ, S_WAITCS} state_t;

  // [0],[1] form the synchroniser; [2] is the previous synced value for edges
  logic [2:0] sclk_sync_q, cs_sync_q;
  logic [1:0] mosi_sync_q;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               sh_q, sh_d;
  logic [7:0]               cmd_q, cmd_d;
  logic [RD_W-1:0]          rd_sh_q, rd_sh_d;
  logic [4:0][SEL_W-1:0]    shadow_q, shadow_d, sel_q, sel_d;
  logic [2:0]               dcs_q, dcs_d;
  logic                     err_q, err_d;
  logic [RLY_W-1:0]         rly_q, rly_d;
  logic                     rly_out_q, rly_out_d;
`ifdef SPI_CTRL_WDOG_EN
  logic [WD_W-1:0]          wdog_q, wdog_d;
`endif

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_s, mosi_s;
  logic [7:0] byte_in;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_s      = cs_sync_q[1];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];
  assign byte_in   = {sh_q[6:0], mosi_s};

  // Pin synchronisers; cs resets high so no false frame start is seen
  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  // Frame FSM, command execution, readback shifter and relay pulse timer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    cmd_d     = cmd_q;
    rd_sh_d   = rd_sh_q;
    shadow_d  = shadow_q;
    sel_d     = sel_q;
    dcs_d     = dcs_q;
    err_d     = err_q;
    rly_d     = (rly_q != '0) ? rly_q - 1'b1 : rly_q;
`ifdef SPI_CTRL_WDOG_EN
    wdog_d    = (sclk_rise || sclk_fall || cs_fall) ? '0 :
                (wdog_q != WD_W'(WDOG_CYC)) ? wdog_q + 1'b1 : wdog_q;
`endif
    // The falling edge that closes the command byte is skipped (cnt==0) so
    // the snapshot MSB is what the host samples on the first data rise.
    if (sclk_fall && ((state_q == S_READ && cnt_q != '0) || state_q == S_WAITCS))
      rd_sh_d = {rd_sh_q[RD_W-2:0], 1'b0};

    case (state_q)
      S_IDLE: begin
        rd_sh_d = '0;
        if (cs_fall) begin
          state_d = S_CMD;
          cnt_d   = '0;
        end
      end
      S_CMD: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          if (cnt_q != '0) err_d = 1'b1;
        end else if (sclk_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(7)) begin
            cnt_d = '0;
            cmd_d = byte_in;
            if (byte_in == 8'h05) begin
              state_d = S_READ;
              rd_sh_d = {count_p, count_m};
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(7)) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WAITCS;
        case (cmd_q)
          8'h01: begin
            if (sh_q[7:4] >= 4'd1 && sh_q[7:4] <= 4'd5) begin
              for (int i = 0; i < 5; i++)
                if (sh_q[7:4] == 4'(i + 1)) shadow_d[i] = SEL_W'(sh_q[3:0]);
            end else begin
              err_d = 1'b1;
            end
          end
          8'h02: sel_d = shadow_q;
          8'h03: begin
            case (sh_q)
              8'h01:   dcs_d = 3'b001;
              8'h02:   dcs_d = 3'b010;
              8'h03:   dcs_d = 3'b100;
              8'h04:   rly_d = RLY_W'(RLY_PULSE);
              8'h0F:   dcs_d = 3'b000;
              default: err_d = 1'b1;
            endcase
          end
          8'h04:   err_d = 1'b0;
          default: err_d = 1'b1;
        endcase
      end
      S_READ: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(RD_W - 1)) state_d = S_WAITCS;
        end
      end
      S_WAITCS: if (cs_s) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

`ifdef SPI_CTRL_WDOG_EN
    // Stalled frame: abandon it without writing anything
    if ((state_q == S_CMD || state_q == S_DATA || state_q == S_READ) && !cs_s &&
        !sclk_rise && !sclk_fall && wdog_q == WD_W'(WDOG_CYC)) begin
      state_d  = S_WAITCS;
      err_d    = 1'b1;
      shadow_d = shadow_q;
      sel_d    = sel_q;
      dcs_d    = dcs_q;
    end
`endif
    rly_out_d = (rly_d != '0);
  end

  // State and datapath registers
  always_ff @(posedge clk_12mhz or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      cmd_q     <= '0;
      rd_sh_q   <= '0;
      shadow_q  <= '0;
      sel_q     <= '0;
      dcs_q     <= '0;
      err_q     <= 1'b0;
      rly_q     <= '0;
      rly_out_q <= 1'b0;
`ifdef SPI_CTRL_WDOG_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      cmd_q     <= cmd_d;
      rd_sh_q   <= rd_sh_d;
      shadow_q  <= shadow_d;
      sel_q     <= sel_d;
      dcs_q     <= dcs_d;
      err_q     <= err_d;
      rly_q     <= rly_d;
      rly_out_q <= rly_out_d;
`ifdef SPI_CTRL_WDOG_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign spi_miso    = rd_sh_q[RD_W-1];
  assign input_sel   = sel_q[0];
  assign mu_sel      = sel_q[1];
  assign avk_sel     = sel_q[2];
  assign fil1_sel    = sel_q[3];
  assign fil2_sel    = sel_q[4];
  assign comp1_cs    = dcs_q[0];
  assign comp2_cs    = dcs_q[1];
  assign relay_cs    = dcs_q[2];
  assign relay_reset = rly_out_q;
  assign frame_err   = err_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: scoreboard bench for spi_cmd_ctrl.
// Stimulus drives SPI frames and pushes expectations from a frame-level
// model; independent monitors pop and compare output state, MISO bits and
// relay pulse lengths.
module tb_spi_cmd_ctrl;
  localparam int CNT_W = 24;
  localparam int SEL_W = 4;
  localparam int RLY   = 12000;
`ifdef SPI_CTRL_WDOG_EN
  localparam int WD    = 2000;
`endif

  logic clk = 1'b0, rst_n = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic spi_miso, comp1_cs, comp2_cs, relay_cs, relay_reset, frame_err;
  logic [CNT_W-1:0] count_p = '0, count_m = '0;
  logic [SEL_W-1:0] input_sel, mu_sel, avk_sel, fil1_sel, fil2_sel;

  always #5 clk = ~clk;

  spi_cmd_ctrl #(
    .CNT_W(CNT_W), .SEL_W(SEL_W), .RLY_PULSE(RLY)
`ifdef SPI_CTRL_WDOG_EN
    , .WDOG_CYC(WD)
`endif
  ) dut (
    .clk_12mhz(clk), .rst(rst_n), .spi_clk(sclk), .spi_cs(cs), .spi_mosi(mosi),
    .spi_miso(spi_miso), .count_p(count_p), .count_m(count_m),
    .input_sel(input_sel), .mu_sel(mu_sel), .avk_sel(avk_sel),
    .fil1_sel(fil1_sel), .fil2_sel(fil2_sel),
    .comp1_cs(comp1_cs), .comp2_cs(comp2_cs), .relay_cs(relay_cs),
    .relay_reset(relay_reset), .frame_err(frame_err)
  );

  typedef struct packed {
    logic [4:0][3:0] sel;
    logic [2:0]      dcs;
    logic            err;
  } obs_t;

  obs_t act;
  assign act = {fil2_sel, fil1_sel, avk_sel, mu_sel, input_sel,
                relay_cs, comp2_cs, comp1_cs, frame_err};

  obs_t exp_q[$];
  logic miso_q[$];
  int   rly_q[$];
  int   checks = 0, errors = 0;

  // Frame-level reference model
  logic [3:0] m_sh[5], m_out[5];
  logic [2:0] m_dcs;
  logic       m_err;

  function automatic obs_t m_obs();
    obs_t o;
    for (int i = 0; i < 5; i++) o.sel[i] = m_out[i];
    o.dcs = m_dcs;
    o.err = m_err;
    return o;
  endfunction

  function automatic void m_apply(input logic [7:0] c, input logic [7:0] d, input int nb);
    int f;
    if (nb == 0) return;
    if (nb < 16) begin m_err = 1'b1; return; end
    case (c)
      8'h01: begin
        f = int'(d[7:4]);
        if (f >= 1 && f <= 5) m_sh[f-1] = d[3:0];
        else m_err = 1'b1;
      end
      8'h02: for (int i = 0; i < 5; i++) m_out[i] = m_sh[i];
      8'h03: case (d)
        8'h01: m_dcs = 3'b001;
        8'h02: m_dcs = 3'b010;
        8'h03: m_dcs = 3'b100;
        8'h04: ;
        8'h0F: m_dcs = 3'b000;
        default: m_err = 1'b1;
      endcase
      8'h04: m_err = 1'b0;
      default: m_err = 1'b1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0: data set while clock low, sampled on rise
  task automatic spi_bit(input logic b);
    mosi = b;
    wclk(4);
    sclk = 1'b1;
    wclk(4);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input int nb,
                            output longint t16);
    logic [15:0] w;
    w = {c, d};
    t16 = 0;
    cs = 1'b0;
    wclk(4);
    for (int i = 0; i < nb; i++) begin
      if (i == 15) t16 = longint'($time);
      spi_bit(w[15-i]);
    end
    wclk(4);
    cs = 1'b1;
    wclk(10);
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] d, input int nb);
    longint t;
    send_frame(c, d, nb, t);
    m_apply(c, d, nb);
    exp_q.push_back(m_obs());
  endtask

  task automatic do_read(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] m, input int ndata);
    logic [2*CNT_W-1:0] v;
    logic [7:0] cr;
    v = {p, m};
    cr = 8'h05;
    count_p = p;
    count_m = m;
    cs = 1'b0;
    wclk(4);
    for (int i = 0; i < 8; i++) spi_bit(cr[7-i]);
    for (int j = 0; j < ndata; j++) begin
      if (j == 5) begin
        count_p = CNT_W'($urandom);
        count_m = CNT_W'($urandom);
      end
      miso_q.push_back(j < 2*CNT_W ? v[2*CNT_W-1-j] : 1'b0);
      spi_bit(1'b0);
    end
    wclk(4);
    cs = 1'b1;
    wclk(10);
    if (ndata < 2*CNT_W) m_err = 1'b1;
    exp_q.push_back(m_obs());
    chk("miso_idle", 64'(spi_miso), 64'd0);
  endtask

  // Monitor: output state after each frame
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) chk("outputs", 64'(act), 64'(exp_q.pop_front()));
  end

  // Monitor: MISO as seen by the host on each rising SPI clock
  initial forever begin
    @(posedge sclk);
    if (miso_q.size() > 0) chk("miso_bit", 64'(spi_miso), 64'(miso_q.pop_front()));
  end

  // Monitor: relay pulse length in clk cycles
  initial forever begin
    int  len;
    bit  done;
    @(posedge relay_reset);
    len = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (relay_reset === 1'b1 && len < 200000) len++;
      else done = 1'b1;
    end
    if (rly_q.size() == 0) chk("relay_unexpected", 64'(len), 64'd0);
    else chk("relay_len", 64'(len), 64'(rly_q.pop_front()));
  end

  initial begin
    longint ta, tb;
    logic [7:0] c, d;
    int r, nb;
    for (int i = 0; i < 5; i++) begin m_sh[i] = '0; m_out[i] = '0; end
    m_dcs = '0;
    m_err = 1'b0;
    #2 rst_n = 1'b0;
    wclk(3);
    rst_n = 1'b1;
    wclk(3);
    exp_q.push_back(m_obs());
    wclk(2);
    chk("reset_miso", 64'(spi_miso), 64'd0);
    chk("reset_relay", 64'(relay_reset), 64'd0);

    // Shadow write, then commit
    frame(8'h01, 8'h23, 16);
    frame(8'h02, 8'h00, 16);
    // Device selects
    frame(8'h03, 8'h01, 16);
    frame(8'h03, 8'h03, 16);
    frame(8'h03, 8'h0F, 16);
    // Aborts and error handling
    frame(8'h01, 8'h15, 11);
    frame(8'h04, 8'h00, 16);
    frame(8'h01, 8'h15, 0);
    frame(8'h07, 8'h00, 16);
    frame(8'h04, 8'h00, 16);
    frame(8'h01, 8'h69, 16);
    frame(8'h01, 8'h09, 16);
    frame(8'h03, 8'h55, 16);

    // Randomised frames (no relay pulses here)
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(0, 9);
      nb = 16;
      d  = 8'($urandom);
      c  = 8'h01;
      case (r)
        0, 1, 2: d[7:4] = 4'($urandom_range(0, 7));
        3, 8:    c = 8'h02;
        4, 5: begin
          c = 8'h03;
          case ($urandom_range(0, 4))
            0: d = 8'h01;
            1: d = 8'h02;
            2: d = 8'h03;
            3: d = 8'h0F;
            default: d = 8'($urandom_range(16, 255));
          endcase
        end
        6: c = 8'h04;
        7: c = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(6, 255));
        default: nb = $urandom_range(0, 15);
      endcase
      frame(c, d, nb);
    end
    frame(8'h04, 8'h00, 16);

    // Readback: snapshot, extra zero bits, abort mid-read
    do_read(24'hABCDEF, 24'h123456, 50);
    do_read(CNT_W'($urandom), CNT_W'($urandom), 48);
    do_read(CNT_W'($urandom), CNT_W'($urandom), 20);
    frame(8'h04, 8'h00, 16);

`ifdef SPI_CTRL_WDOG_EN
    cs = 1'b0;
    wclk(4);
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    wclk(WD + 100);
    m_err = 1'b1;
    exp_q.push_back(m_obs());
    wclk(3);
    cs = 1'b1;
    wclk(10);
    frame(8'h04, 8'h00, 16);
    frame(8'h03, 8'h02, 16);
`endif

    // Relay pulse: single, then restarted mid-pulse
    rly_q.push_back(RLY);
    frame(8'h03, 8'h04, 16);
    wclk(RLY + 200);
    send_frame(8'h03, 8'h04, 16, ta);
    m_apply(8'h03, 8'h04, 16);
    exp_q.push_back(m_obs());
    wclk(5850);
    send_frame(8'h03, 8'h04, 16, tb);
    m_apply(8'h03, 8'h04, 16);
    exp_q.push_back(m_obs());
    rly_q.push_back(int'((tb - ta) / 10) + RLY);
    wclk(RLY + 200);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("miso_q_drained", 64'(miso_q.size()), 64'd0);
    chk("rly_q_drained", 64'(rly_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
